obi_sram_slave: RTL
===================

OBI_SRAM_SLAVE -- requirements
Module: obi_sram_slave

Interface
REQ-001 Parameter NUM_WORDS, default 64, number of 32-bit words (power of two, 2..4096).
REQ-002 Parameter LATENCY, default 1, cycles from grant edge to response (1..4).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  OBI request valid.
REQ-006 gnt  output  1  OBI grant; a transfer is accepted on a rising edge with req=1 and gnt=1.
REQ-007 addr  input  32  byte address.
REQ-008 we  input  1  1=write, 0=read.
REQ-009 be  input  4  byte enables, lane-aligned (be[i] selects bits 8i+7:8i).
REQ-010 wdata  input  32  write data, lane-aligned.
REQ-011 rvalid  output  1  response valid, one cycle per accepted transfer.
REQ-012 rdata  output  32  read data, lane-aligned.
REQ-013 err  output  1  error response, qualified by rvalid.

Function
REQ-014 Legal be patterns SHALL be 1111, 0011, 1100, 0001, 0010, 0100, 1000; all others (incl. 0000) are illegal.
REQ-015 A transfer SHALL be erroneous if be is illegal, addr[1:0] differs from the index of the lowest set be bit, or addr >= 4*NUM_WORDS.
REQ-016 Word index SHALL be addr[log2(NUM_WORDS)+1:2].
REQ-017 An accepted legal write SHALL update only enabled byte lanes of the addressed word on the accepting edge.
REQ-018 An erroneous write SHALL leave memory unchanged.
REQ-019 An accepted legal read SHALL sample the word on the accepting edge; enabled lanes return memory data, disabled lanes return 0.
REQ-020 Every accepted transfer SHALL produce exactly one rvalid=1 cycle exactly LATENCY cycles after the accepting edge, in acceptance order.
REQ-021 Responses SHALL be pipelined: one transfer may be accepted per cycle, up to LATENCY in flight.
REQ-022 Write responses SHALL carry rdata=0, err=0 when legal.
REQ-023 Erroneous responses SHALL carry err=1, rdata=32'hDEADBEEF.
REQ-024 When rvalid=0, rdata and err SHALL be 0.
REQ-025 A read accepted the cycle after a write to the same word SHALL return the newly written data.
REQ-026 Requests with gnt=0 SHALL have no side effect; the manager holds req and attributes until granted.

Reset
REQ-027 While reset=1: gnt=0, rvalid=0, rdata=0, err=0, response pipeline cleared.
REQ-028 Transfers in flight at reset assertion SHALL be dropped with no rvalid produced.
REQ-029 Memory contents SHALL not be reset; a write accepted on the same edge reset is sampled high SHALL not occur since gnt=0.
REQ-030 First possible grant SHALL be the first cycle with reset=0.

Configuration
REQ-031 Macro OBI_MEM_STALL_EN SHALL compile in grant throttling for handshake stress testing.
REQ-032 With OBI_MEM_STALL_EN: 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 at reset, advancing every cycle; gnt=0 when lfsr[1:0]=2'b00, else gnt=1 (reset=0).
REQ-033 Without OBI_MEM_STALL_EN: gnt=1 whenever reset=0; no LFSR logic present.

Verification
REQ-034 LATENCY=1: write addr 0x10, be 1111, wdata 0xCAFEF00D; next cycle read addr 0x10, be 1111 -> second rvalid with rdata 0xCAFEF00D, err 0.
REQ-035 Write addr 0x22, be 1100, wdata 0xBEEF0000 over word 0x11223344 at 0x20; read addr 0x20, be 1111 -> rdata 0xBEEF3344.
REQ-036 Read addr 0x21, be 0010 after REQ-035 -> rdata 0x00003300; read addr 0x21, be 0100 -> err 1, rdata 0xDEADBEEF.
REQ-037 NUM_WORDS=64: write addr 0x100, be 1111 -> err 1, memory unchanged (readback of 0x000 unaltered); be 0101 at 0x0 -> err 1.
REQ-038 LATENCY=3: four back-to-back reads granted consecutive cycles -> four consecutive rvalid cycles starting 3 cycles after first grant, in order; reset asserted after the second grant -> no further rvalid.
REQ-039 OBI_MEM_STALL_EN defined: 1000 random transfers with req held until gnt -> each completes exactly once, data matches reference model, at least one gnt=0 cycle observed.

Source files
------------

// File: rtl/obi_sram_slave.sv
// obi_sram_slave
//   Single-port SRAM behind an OBI slave port. It has a fixed-latency response
//   pipeline, per-byte-lane writes and checking for bad byte enables and bad
//   addresses.
//
// Parameters
//   NUM_WORDS  number of 32-bit words (power of two, 2..4096)
//   LATENCY    cycles from the accepting edge to rvalid (1..4)
//
// Ports
//   clk     sole clock, rising edge
//   reset   synchronous, active-high
//   req     request valid            gnt    grant (accept = req & gnt)
//   addr    byte address             we     1 = write, 0 = read
//   be      byte enables             wdata  write data (lane aligned)
//   rvalid  response valid           rdata  read data (lane aligned)
//   err     error response, qualified by rvalid
//
// Build option
//   OBI_MEM_STALL_EN  when defined, an 8-bit LFSR throttles gnt to stress the
//                     manager's handshake logic.

module obi_sram_slave #(
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        gnt,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = $clog2(NUM_WORDS);

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } resp_t;

    logic [31:0]   mem [NUM_WORDS];
    resp_t         pipe [LATENCY];

    logic          accept;
    logic          be_legal;
    logic [1:0]    be_low;
    logic          in_range;
    logic          bad;
    logic [AW-1:0] widx;
    logic [31:0]   lane_mask;
    logic [31:0]   resp_data;

`ifdef OBI_MEM_STALL_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; it never reaches zero from a nonzero seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign gnt = !reset && (lfsr[1:0] != 2'b00);
`else
    assign gnt = !reset;
`endif

    assign accept = req && gnt;

    // Legal patterns and the byte offset each one requires in addr[1:0].
    always_comb begin
        be_legal = 1'b1;
        be_low   = 2'd0;
        case (be)
            4'b1111: be_low = 2'd0;
            4'b0011: be_low = 2'd0;
            4'b1100: be_low = 2'd2;
            4'b0001: be_low = 2'd0;
            4'b0010: be_low = 2'd1;
            4'b0100: be_low = 2'd2;
            4'b1000: be_low = 2'd3;
            default: be_legal = 1'b0;
        endcase
    end

    assign in_range  = (addr[31:AW+2] == '0);
    assign bad       = !be_legal || (addr[1:0] != be_low) || !in_range;
    assign widx      = addr[AW+1:2];
    assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    always_comb begin
        resp_data = '0;
        if (bad) begin
            resp_data = 32'hDEADBEEF;
        end else if (!we) begin
            resp_data = mem[widx] & lane_mask;
        end
    end

    // Storage is deliberately not reset. While reset is high gnt is 0, so
    // accept cannot be set.
    always_ff @(posedge clk) begin
        if (accept && we && !bad) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response on the accepting edge, so a read issued
    // in the cycle after a write sees the written data. Empty slots carry
    // zero data and zero err, which keeps the outputs clean when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].v <= accept;
            pipe[0].e <= accept && bad;
            pipe[0].d <= accept ? resp_data : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Gating with reset drops in-flight responses as soon as reset rises.
    assign rvalid = !reset && pipe[LATENCY-1].v;
    assign err    = !reset && pipe[LATENCY-1].e;
    assign rdata  = reset ? '0 : pipe[LATENCY-1].d;

endmodule
